// File: rtl/alu_result_decoder.sv
// alu_result_decoder: serial double-dabble binary-to-BCD converter for the ALU result bus,
// one bit per cycle, with sign/overflow flags and a one-cycle done strobe.
module alu_result_decoder (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic [19:0] result_i,
   input  logic        signed_mode_i,
   output logic [23:0] bcd_o,
   output logic        negative_o,
   output logic        overflow_o,
   output logic        out_valid_o
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t      state_q, state_d;
   logic [19:0] shreg_q, shreg_d, mag;
   logic [27:0] scr_q, scr_d, adj;
   logic [4:0]  cnt_q, cnt_d;
   logic        sign_q, sign_d;
   logic [23:0] bcd_q, bcd_d;
   logic        neg_q, neg_d;
   logic        ovf_q, ovf_d;
   logic [47:0] sh;
   for (genvar g = 0; g < 7; g++) begin : g_adj
      assign adj[4*g+:4] = scr_q[4*g+:4] >= 4'd5 ? scr_q[4*g+:4] + 4'd3 : scr_q[4*g+:4];
   end
   assign sh          = {adj, shreg_q} << 1;
   assign mag         = signed_mode_i && result_i[19] ? ~result_i + 20'd1 : result_i;
   assign in_ready_o  = state_q == IDLE;
   assign out_valid_o = state_q == DONE;
   assign bcd_o       = bcd_q;
   assign negative_o  = neg_q;
   assign overflow_o  = ovf_q;
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      scr_d   = scr_q;
      cnt_d   = cnt_q;
      sign_d  = sign_q;
      bcd_d   = bcd_q;
      neg_d   = neg_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         IDLE: if (in_valid_i) begin
            state_d = SHIFT;
            shreg_d = mag;
            scr_d   = '0;
            cnt_d   = '0;
            sign_d  = signed_mode_i & result_i[19];
         end
         SHIFT: begin
            {scr_d, shreg_d} = sh;
            cnt_d            = cnt_q + 5'd1;
            // count 19 means this edge performs the 20th and final shift
            if (cnt_q == 5'd19) begin
               state_d = DONE;
               ovf_d   = sh[47:44] != 4'd0;
               bcd_d   = ovf_d ? 24'h999999 : sh[43:20];
               neg_d   = sign_q;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         shreg_q <= '0;
         scr_q   <= '0;
         cnt_q   <= '0;
         sign_q  <= 1'b0;
         bcd_q   <= '0;
         neg_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         scr_q   <= scr_d;
         cnt_q   <= cnt_d;
         sign_q  <= sign_d;
         bcd_q   <= bcd_d;
         neg_q   <= neg_d;
         ovf_q   <= ovf_d;
      end
   end
endmodule

// File: tb/tb_alu_result_decoder.sv
// tb_alu_result_decoder: table-driven and scoreboarded bench for the BCD result decoder.
module tb_alu_result_decoder;
   logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, signed_mode = 1'b0;
   logic [19:0] result = '0;
   logic        in_ready, negative, overflow, out_valid;
   logic [23:0] bcd;

   typedef struct {logic [19:0] val; logic sm; logic [23:0] bcd; logic neg; logic ovf;} vec_t;
   typedef struct {logic [23:0] bcd; logic neg; logic ovf;} exp_t;

   exp_t exp_q[$];
   int   acc_q[$];
   int   ov_cyc[$];
   int   cyc = 0;
   int   checks = 0, errors = 0;

   alu_result_decoder dut (
      .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .result_i(result), .signed_mode_i(signed_mode), .bcd_o(bcd),
      .negative_o(negative), .overflow_o(overflow), .out_valid_o(out_valid)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic exp_t model(input logic [19:0] v, input logic sm);
      exp_t e;
      int   m;
      m     = (sm && v[19]) ? (1 << 20) - int'(v) : int'(v);
      e.neg = sm && v[19];
      e.ovf = m > 999999;
      e.bcd = 24'h999999;
      if (!e.ovf)
         for (int i = 0; i < 6; i++) begin
            e.bcd[4*i+:4] = 4'(m % 10);
            m = m / 10;
         end
      return e;
   endfunction

   always @(negedge clk) begin : mon
      exp_t e;
      if (out_valid === 1'b1) begin
         ov_cyc.push_back(cyc);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_out_valid: got 1 expected 0 (cycle %0d)", cyc);
         end else begin
            e = exp_q.pop_front();
            chk("bcd", 32'(bcd), 32'(e.bcd));
            chk("negative", 32'(negative), 32'(e.neg));
            chk("overflow", 32'(overflow), 32'(e.ovf));
            chk("latency", cyc - acc_q.pop_front(), 20);
         end
      end
   end

   task automatic wait_ready();
      int n = 0;
      while (in_ready !== 1'b1 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (in_ready !== 1'b1) chk("ready_timeout", 32'(in_ready), 1);
   endtask

   task automatic convert(input logic [19:0] v, input logic sm, input exp_t e);
      wait_ready();
      in_valid    = 1'b1;
      result      = v;
      signed_mode = sm;
      @(posedge clk);
      #1;
      exp_q.push_back(e);
      acc_q.push_back(cyc);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk);
         n++;
      end
      if (exp_q.size() != 0) chk("drain_timeout", exp_q.size(), 0);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t tbl[11];
      exp_t e;
      logic [19:0] v;
      logic sm;
      int n;
      tbl[0]  = '{20'h00000, 1'b0, 24'h000000, 1'b0, 1'b0};
      tbl[1]  = '{20'h78000, 1'b0, 24'h491520, 1'b0, 1'b0};
      tbl[2]  = '{20'hFFFF1, 1'b1, 24'h000015, 1'b1, 1'b0};
      tbl[3]  = '{20'hFFFFF, 1'b0, 24'h999999, 1'b0, 1'b1};
      tbl[4]  = '{20'h80000, 1'b1, 24'h524288, 1'b1, 1'b0};
      tbl[5]  = '{20'hF423F, 1'b0, 24'h999999, 1'b0, 1'b0};
      tbl[6]  = '{20'hF4240, 1'b0, 24'h999999, 1'b0, 1'b1};
      tbl[7]  = '{20'h7FFFF, 1'b1, 24'h524287, 1'b0, 1'b0};
      tbl[8]  = '{20'hFFFFF, 1'b1, 24'h000001, 1'b1, 1'b0};
      tbl[9]  = '{20'h80000, 1'b0, 24'h524288, 1'b0, 1'b0};
      tbl[10] = '{20'h00000, 1'b1, 24'h000000, 1'b0, 1'b0};

      #1;
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_bcd", 32'(bcd), 0);
      chk("rst_negative", 32'(negative), 0);
      chk("rst_overflow", 32'(overflow), 0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         e = '{tbl[i].bcd, tbl[i].neg, tbl[i].ovf};
         convert(tbl[i].val, tbl[i].sm, e);
      end
      for (int i = 0; i < 6; i++) begin
         v  = 20'($urandom);
         sm = 1'($urandom_range(0, 1));
         convert(v, sm, model(v, sm));
      end
      drain();

      // back-to-back: 30 then 1000 with in_valid held, junk during SHIFT
      wait_ready();
      in_valid    = 1'b1;
      result      = 20'd30;
      signed_mode = 1'b0;
      @(posedge clk);
      #1;
      exp_q.push_back('{24'h000030, 1'b0, 1'b0});
      acc_q.push_back(cyc);
      chk("b2b_ready_e0", 32'(in_ready), 0);
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         #1;
         chk("b2b_ready_busy", 32'(in_ready), 0);
         if (k < 20) begin
            in_valid    = (k % 2) == 1;
            result      = 20'($urandom);
            signed_mode = 1'($urandom_range(0, 1));
         end else begin
            in_valid    = 1'b1;
            result      = 20'd1000;
            signed_mode = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      chk("b2b_ready_e21", 32'(in_ready), 1);
      @(posedge clk);
      #1;
      exp_q.push_back('{24'h001000, 1'b0, 1'b0});
      acc_q.push_back(cyc);
      in_valid = 1'b0;
      chk("b2b_ready_e22", 32'(in_ready), 0);
      drain();
      n = ov_cyc.size();
      chk("b2b_strobe_gap", ov_cyc[n-1] - ov_cyc[n-2], 22);

      // mid-conversion reset aborts with no strobe
      wait_ready();
      in_valid    = 1'b1;
      result      = 20'd999999;
      signed_mode = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_bcd", 32'(bcd), 0);
      chk("abort_negative", 32'(negative), 0);
      chk("abort_overflow", 32'(overflow), 0);
      chk("abort_in_ready", 32'(in_ready), 1);
      chk("abort_out_valid", 32'(out_valid), 0);
      n = ov_cyc.size();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (25) @(posedge clk);
      #1;
      chk("abort_no_strobe", ov_cyc.size(), n);
      convert(20'd123456, 1'b0, '{24'h123456, 1'b0, 1'b0});
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
